// File: rtl/latch_enable_gen.sv
// latch_enable_gen: pulse-enable sequencer for the pulsed-latch shift register bank.
// A single accepted start issues WIDTH one-cycle En1 pulses (shift modes) or a
// single En2 pulse (parallel load), spaced by GAP idle cycles, then strobes done.
module latch_enable_gen #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic             abort,
    output logic [2:0]       sel_out,
    output logic             En1,
    output logic             En2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] shift_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0]       SEL_LOAD     = 3'b010;
    localparam logic [1:0]       GAP_LOAD     = (GAP > 0) ? 2'(GAP - 1) : 2'd0;
    localparam logic [CNT_W-1:0] SHIFT_REMAIN = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [CNT_W-1:0] remaining_r;
    logic [1:0]       gap_r;

    // Shift modes that drive En1 pulses.
    function automatic logic sel_is_shift(input logic [2:0] s);
        case (s)
            3'b000, 3'b001, 3'b011, 3'b100: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Sequencer: state always reflects what the outputs currently show. The
    // accepting edge already emits the first pulse, so remaining/shift_cnt are
    // loaded one step ahead (WIDTH-1 left, one issued) to make the first pulse
    // visible in the cycle right after start is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= {CNT_W{1'b0}};
            gap_r       <= 2'd0;
            sel_out     <= 3'b000;
            En1         <= 1'b0;
            En2         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            shift_cnt   <= {CNT_W{1'b0}};
        end else begin
            En1  <= 1'b0;
            En2  <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else if (start) begin
                        if (sel_is_shift(sel) || (sel == SEL_LOAD)) begin
                            state_r     <= ST_PULSE;
                            sel_out     <= sel;
                            En1         <= (sel != SEL_LOAD);
                            En2         <= (sel == SEL_LOAD);
                            busy        <= 1'b1;
                            shift_cnt   <= CNT_W'(1);
                            remaining_r <= (sel == SEL_LOAD) ? {CNT_W{1'b0}} : SHIFT_REMAIN;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (remaining_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (GAP == 0) begin
                        state_r     <= ST_PULSE;
                        En1         <= (sel_out != SEL_LOAD);
                        En2         <= (sel_out == SEL_LOAD);
                        shift_cnt   <= shift_cnt + CNT_W'(1);
                        remaining_r <= remaining_r - CNT_W'(1);
                    end else begin
                        state_r <= ST_GAP;
                        gap_r   <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (gap_r == 2'd0) begin
                        state_r     <= ST_PULSE;
                        En1         <= (sel_out != SEL_LOAD);
                        En2         <= (sel_out == SEL_LOAD);
                        shift_cnt   <= shift_cnt + CNT_W'(1);
                        remaining_r <= remaining_r - CNT_W'(1);
                    end else begin
                        gap_r <= gap_r - 2'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
